cl_frame_gen: RTL and testbench

CL_FRAME_GEN -- requirements
Module: cl_frame_gen

---
 rtl/cl_frame_gen.sv | 204 ++++++++++++++++++++
 tb/tb_cl_frame_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_frame_gen.sv
// Camera Link test-pattern frame generator: FRONT/LINE/HBLK/VBLK timing with per-tap pattern lanes.
// Optional: define CL_GEN_FRAME_CNT_EN to stamp frame_cnt into tap 0 of each frame's first beat.

module cl_frame_gen_tap #(
    parameter int PIX_W = 12,
    parameter int K     = 0
) (
    input  logic [15:0]      x_base,
    input  logic [15:0]      y,
    input  logic [1:0]       pattern,
    output logic [PIX_W-1:0] pix
);
    localparam logic [PIX_W-1:0] ALT = {(PIX_W/2){2'b10}};

    logic [15:0] x;
    assign x = x_base + 16'(K);

    always_comb begin
        case (pattern)
            2'd0:    pix = PIX_W'(x);
            2'd1:    pix = PIX_W'(y);
            2'd2:    pix = {PIX_W{x[3] ^ y[3]}};
            default: pix = ALT;
        endcase
    end
endmodule

module cl_frame_gen #(
    parameter int TAPS  = 4,
    parameter int PIX_W = 12
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic [7:0]            hblank,
    input  logic [15:0]           vblank,
    input  logic [1:0]            pattern,
    output logic                  fval,
    output logic                  lval,
    output logic                  dval,
    output logic [TAPS*PIX_W-1:0] pix_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err,
    output logic [15:0]           frame_cnt
);
    localparam logic [15:0] T16 = 16'(TAPS);

    typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLK, VBLK} state_t;

    state_t      state;
    logic [15:0] width_r, height_r, vblank_r;
    logic [7:0]  hblank_r;
    logic [1:0]  pattern_r;
    logic [15:0] nxt_x, nxt_y;   // coordinates of the next beat to be emitted
    logic [15:0] cnt;            // blanking cycles remaining, including current
    logic [15:0] hb_len, vb_len;
    logic        cfg_ok;

    logic [TAPS-1:0][PIX_W-1:0] tap_pix, beat_pix;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        cl_frame_gen_tap #(.PIX_W(PIX_W), .K(k)) u_tap (
            .x_base (nxt_x),
            .y      (nxt_y),
            .pattern(pattern_r),
            .pix    (tap_pix[k])
        );
    end

`ifdef CL_GEN_FRAME_CNT_EN
    always_comb begin
        beat_pix = tap_pix;
        if (nxt_x == 16'd0 && nxt_y == 16'd0)
            beat_pix[0] = PIX_W'(frame_cnt);
    end
`else
    assign beat_pix = tap_pix;
`endif

    assign cfg_ok = (frame_width != 16'd0) && (frame_height != 16'd0) &&
                    ((frame_width % T16) == 16'd0);
    assign hb_len = (hblank_r == 8'd0)  ? 16'd1 : {8'd0, hblank_r};
    assign vb_len = (vblank_r == 16'd0) ? 16'd1 : vblank_r;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            width_r    <= '0;
            height_r   <= '0;
            vblank_r   <= '0;
            hblank_r   <= '0;
            pattern_r  <= '0;
            nxt_x      <= '0;
            nxt_y      <= '0;
            cnt        <= '0;
            fval       <= 1'b0;
            lval       <= 1'b0;
            dval       <= 1'b0;
            pix_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            width_r   <= frame_width;
                            height_r  <= frame_height;
                            hblank_r  <= hblank;
                            vblank_r  <= vblank;
                            pattern_r <= pattern;
                            nxt_x     <= '0;
                            nxt_y     <= '0;
                            state     <= FRONT;
                            fval      <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FRONT: begin
                    state    <= LINE;
                    lval     <= 1'b1;
                    dval     <= 1'b1;
                    pix_data <= beat_pix;
                    nxt_x    <= nxt_x + T16;
                end
                LINE: begin
                    if (nxt_x == width_r) begin
                        lval     <= 1'b0;
                        dval     <= 1'b0;
                        pix_data <= '0;
                        nxt_x    <= '0;
                        if (nxt_y == height_r - 16'd1) begin
                            state      <= VBLK;
                            fval       <= 1'b0;
                            cnt        <= vb_len;
                            frame_done <= (vb_len == 16'd1);
                            if (vb_len == 16'd1)
                                frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            state <= HBLK;
                            cnt   <= hb_len;
                            nxt_y <= nxt_y + 16'd1;
                        end
                    end else begin
                        pix_data <= beat_pix;
                        nxt_x    <= nxt_x + T16;
                    end
                end
                HBLK: begin
                    if (cnt == 16'd1) begin
                        state    <= LINE;
                        lval     <= 1'b1;
                        dval     <= 1'b1;
                        pix_data <= beat_pix;
                        nxt_x    <= nxt_x + T16;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                VBLK: begin
                    if (cnt == 16'd1) begin
                        // continuous restart re-samples config like a fresh start
                        if (continuous && cfg_ok) begin
                            width_r   <= frame_width;
                            height_r  <= frame_height;
                            hblank_r  <= hblank;
                            vblank_r  <= vblank;
                            pattern_r <= pattern;
                            nxt_x     <= '0;
                            nxt_y     <= '0;
                            state     <= FRONT;
                            fval      <= 1'b1;
                        end else begin
                            cfg_err <= continuous;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                        if (cnt == 16'd2) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cl_frame_gen.sv
// Scoreboard bench for cl_frame_gen: stimulus pushes expected per-cycle records, a negedge monitor pops and compares.
module tb_cl_frame_gen;
    localparam int TAPS  = 4;
    localparam int PIX_W = 12;
    localparam int DW    = TAPS * PIX_W;

    logic          sys_clk, sys_rst, start, continuous;
    logic [15:0]   frame_width, frame_height, vblank;
    logic [7:0]    hblank;
    logic [1:0]    pattern;
    logic          fval, lval, dval, busy, frame_done, cfg_err;
    logic [DW-1:0] pix_data;
    logic [15:0]   frame_cnt;

    typedef struct packed {
        logic          fval, lval, dval, busy, done;
        logic [15:0]   fcnt;
        logic [DW-1:0] pix;
    } rec_t;

    rec_t        exp_q[$];
    int          err_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] fc;

    cl_frame_gen #(.TAPS(TAPS), .PIX_W(PIX_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .continuous(continuous),
        .frame_width(frame_width), .frame_height(frame_height), .hblank(hblank),
        .vblank(vblank), .pattern(pattern), .fval(fval), .lval(lval), .dval(dval),
        .pix_data(pix_data), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
        .frame_cnt(frame_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] px(input int x, input int y, input logic [1:0] pat);
        case (pat)
            2'd0:    return PIX_W'(x);
            2'd1:    return PIX_W'(y);
            2'd2:    return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: return 12'hAAA;
        endcase
    endfunction

    task automatic push_frame(input int w, input int h, input int hb, input int vb,
                              input logic [1:0] pat);
        rec_t r;
        int hbl = (hb == 0) ? 1 : hb;
        int vbl = (vb == 0) ? 1 : vb;
        r = '0; r.fval = 1; r.busy = 1; r.fcnt = fc;
        exp_q.push_back(r);
        for (int y = 0; y < h; y++) begin
            for (int b = 0; b < w / TAPS; b++) begin
                r = '0; r.fval = 1; r.lval = 1; r.dval = 1; r.busy = 1; r.fcnt = fc;
                for (int k = 0; k < TAPS; k++)
                    r.pix[k*PIX_W +: PIX_W] = px(b * TAPS + k, y, pat);
`ifdef CL_GEN_FRAME_CNT_EN
                if (b == 0 && y == 0) r.pix[PIX_W-1:0] = fc[PIX_W-1:0];
`endif
                exp_q.push_back(r);
            end
            if (y < h - 1)
                for (int i = 0; i < hbl; i++) begin
                    r = '0; r.fval = 1; r.busy = 1; r.fcnt = fc;
                    exp_q.push_back(r);
                end
        end
        for (int i = 0; i < vbl; i++) begin
            r = '0; r.busy = 1;
            if (i == vbl - 1) begin
                fc = fc + 16'd1;
                r.done = 1;
            end
            r.fcnt = fc;
            exp_q.push_back(r);
        end
    endtask

    always @(negedge sys_clk) begin
        rec_t a, e;
        a = {fval, lval, dval, busy, frame_done, frame_cnt, pix_data};
        if (busy | fval | lval | dval | frame_done) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_output: got %h expected idle", a);
            end else begin
                e = exp_q.pop_front();
                chk("cycle_rec", a, e);
            end
        end
        if (cfg_err) begin
            if (err_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_cfg_err: got 1 expected 0");
            end else begin
                chk("cfg_err", 96'(cfg_err), 96'(err_q.pop_front()));
            end
        end
    end

    task automatic set_cfg(input int w, input int h, input int hb, input int vb, input int pat);
        frame_width = 16'(w); frame_height = 16'(h); hblank = 8'(hb);
        vblank = 16'(vb); pattern = 2'(pat);
    endtask

    task automatic pulse_start;
        @(posedge sys_clk); #1 start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int i = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && i < max) begin
            @(negedge sys_clk); #1; i++;
        end
        chk({name, "_drain"}, 96'(exp_q.size() + err_q.size()), 96'd0);
        exp_q.delete(); err_q.delete();
    endtask

    task automatic do_reset;
        continuous = 1'b0;
        @(posedge sys_clk); #2 sys_rst = 1'b1;
        @(posedge sys_clk); #2 sys_rst = 1'b0;
        exp_q.delete(); err_q.delete();
        fc = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0]   ftr, ltr, dtr;
        logic [6:0]    f7, l7, d7;
        logic [4:0]    etr;
        logic [DW-1:0] pix_c3, pix_c7;
        int bcnt, fcnt_v, t;

        sys_rst = 1'b1; start = 1'b0; continuous = 1'b0; fc = '0;
        set_cfg(0, 0, 0, 0, 0);
        #1 chk("reset_outputs", {fval, lval, dval, busy, frame_done, cfg_err, frame_cnt, pix_data}, 96'd0);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst = 1'b0;

        // basic frame timing: 8x2, hblank 3, vblank 4, ramp-H
        set_cfg(8, 2, 3, 4, 0);
        push_frame(8, 2, 3, 4, 2'd0);
        pulse_start();
        ftr = '0; ltr = '0; dtr = '0; pix_c3 = '0; pix_c7 = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge sys_clk);
            ftr = {ftr[11:0], fval}; ltr = {ltr[11:0], lval}; dtr = {dtr[11:0], frame_done};
            if (i == 2) pix_c3 = pix_data;
            if (i == 6) pix_c7 = pix_data;
        end
        chk("fval_trace",  96'(ftr), 96'(13'b1111111100000));
        chk("lval_trace",  96'(ltr), 96'(13'b0110001100000));
        chk("done_trace",  96'(dtr), 96'(13'b0000000000010));
        chk("beat1_taps",  96'(pix_c3), 96'(48'h007_006_005_004));
        chk("line1_beat0", 96'(pix_c7), 96'(48'h003_002_001_000));
        drain("basic", 50);
        chk("frame_cnt_1", 96'(frame_cnt), 96'd1);

        // width not a multiple of TAPS
        set_cfg(6, 2, 3, 4, 0);
        err_q.push_back(1);
        pulse_start();
        etr = '0; bcnt = 0; fcnt_v = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            etr = {etr[3:0], cfg_err}; bcnt += int'(busy); fcnt_v += int'(fval);
        end
        chk("cfg_err_trace", 96'(etr), 96'(5'b10000));
        chk("cfg_err_busy",  96'(bcnt), 96'd0);
        chk("cfg_err_fval",  96'(fcnt_v), 96'd0);
        // zero height
        set_cfg(8, 0, 3, 4, 0);
        err_q.push_back(1);
        pulse_start();
        @(negedge sys_clk);
        chk("h0_cfg_err", 96'(cfg_err), 96'd1);
        @(negedge sys_clk);
        chk("h0_idle", 96'({cfg_err, busy}), 96'd0);
        drain("cfg", 10);

        // pattern sweep; config changed and start re-pulsed mid-frame must be ignored
        for (int p = 0; p < 3; p++) begin
            int w, h, hb, vb, pat;
            case (p)
                0: begin w = 4;  h = 3;  hb = 2; vb = 1; pat = 1; end
                1: begin w = 16; h = 10; hb = 1; vb = 2; pat = 2; end
                default: begin w = 8; h = 1; hb = 5; vb = 3; pat = 3; end
            endcase
            set_cfg(w, h, hb, vb, pat);
            push_frame(w, h, hb, vb, 2'(pat));
            pulse_start();
            set_cfg(64, 7, 9, 9, (pat + 1) % 4);
            pulse_start();
            drain($sformatf("pat%0d", pat), 400);
            repeat (3) @(negedge sys_clk);
            chk($sformatf("pat%0d_cnt", pat), 96'(frame_cnt), 96'(fc));
            chk($sformatf("pat%0d_idle", pat), 96'(busy), 96'd0);
        end

        // asynchronous reset mid-LINE
        set_cfg(16, 4, 2, 2, 0);
        push_frame(16, 4, 2, 2, 2'd0);
        pulse_start();
        t = 0;
        do begin @(negedge sys_clk); t++; end while (!lval && t < 20);
        chk("wait_lval", 96'(lval), 96'd1);
        @(posedge sys_clk); #2 sys_rst = 1'b1;
        #1 chk("rst_midline", {fval, lval, dval, busy, frame_done, cfg_err, frame_cnt, pix_data}, 96'd0);
        exp_q.delete(); fc = '0;
        repeat (2) @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        chk("rst_no_resume", 96'(busy), 96'd0);
        push_frame(16, 4, 2, 2, 2'd0);
        pulse_start();
        drain("post_rst", 200);
        chk("post_rst_cnt", 96'(frame_cnt), 96'd1);

        // continuous: three frames, drop during frame 3
        do_reset();
        set_cfg(4, 2, 1, 2, 0);
        continuous = 1'b1;
        repeat (3) push_frame(4, 2, 1, 2, 2'd0);
        pulse_start();
        t = 0;
        do begin @(negedge sys_clk); t++; end while (frame_cnt != 16'd2 && t < 100);
        chk("wait_cnt2", 96'(frame_cnt), 96'd2);
        repeat (2) @(negedge sys_clk);
        continuous = 1'b0;
        drain("cont", 100);
        repeat (5) @(negedge sys_clk);
        chk("cont_cnt3", 96'(frame_cnt), 96'd3);
        chk("cont_idle", 96'(busy), 96'd0);

        // zero blanking, continuous two frames, constant pattern
        do_reset();
        set_cfg(4, 2, 0, 0, 3);
        continuous = 1'b1;
        repeat (2) push_frame(4, 2, 0, 0, 2'd3);
        pulse_start();
        f7 = '0; l7 = '0; d7 = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            f7 = {f7[5:0], fval}; l7 = {l7[5:0], lval}; d7 = {d7[5:0], frame_done};
        end
        continuous = 1'b0;
`ifdef CL_GEN_FRAME_CNT_EN
        chk("f2_tap0", 96'(pix_data[PIX_W-1:0]), 96'(12'h001));
`else
        chk("f2_tap0", 96'(pix_data[PIX_W-1:0]), 96'(12'hAAA));
`endif
        chk("zb_fval", 96'(f7), 96'(7'b1111011));
        chk("zb_lval", 96'(l7), 96'(7'b0101001));
        chk("zb_done", 96'(d7), 96'(7'b0000100));
        drain("zb", 50);
        chk("zb_cnt2", 96'(frame_cnt), 96'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
